clk_divider_multi: RTL

//  Multi-channel programmable clock/tick generator; successor of the fixed single-output divider.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/div_channel.sv | 72 +++++++
 rtl/clk_divider_multi.sv | 42 ++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the alarm-clock timing chain on the 50 MHz board.
package alarm_pkg;

  localparam int unsigned BOARD_CLK_HZ = 50000000;

  // Half-periods in board clock cycles (output period = 2 * half).
  localparam int unsigned DEF_HALF_1HZ   = 25000000;  // seconds tick
  localparam int unsigned DEF_HALF_SCAN  = 25000;     // 1 kHz display scan
  localparam int unsigned TONE_HALF_2KHZ = 12500;     // buzzer tone, high
  localparam int unsigned TONE_HALF_1KHZ = 25000;     // buzzer tone, low

  // Conventional channel assignment on the board.
  typedef enum int unsigned {
    ChSeconds = 0,
    ChScan    = 1,
    ChTone    = 2
  } ch_role_e;

  // Half-period for a wanted output frequency; caller keeps out_hz nonzero.
  function automatic int unsigned half_for_hz(int unsigned clk_hz, int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider slice: loadable half-period, counter, 50%-duty level and toggle strobe.
module div_channel #(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned DEF_HALF = 25000000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clr,
  input  logic             Wr,
  input  logic [CNT_W-1:0] WrVal,
  output logic             ClkOut,
  output logic             Tick
);

  localparam logic [CNT_W-1:0] DefHalf = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wr_ok;

  // A zero half-period is never stored, so the Half-1 compare cannot wrap.
  assign wr_ok = Wr && (WrVal != '0);

  // Next state: clear beats write beats counting; tick only on a counted wrap.
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (Clr) begin
      cnt_d = '0;
      out_d = 1'b0;
      if (wr_ok) begin
        half_d = WrVal;
      end
    end else if (wr_ok) begin
      half_d = WrVal;
      cnt_d  = '0;
    end else if (En) begin
      if (cnt_q == half_q - One) begin
        cnt_d  = '0;
        out_d  = ~out_q;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + One;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      half_q <= DefHalf;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign ClkOut = out_q;
  assign Tick   = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable tick/level generator; all outputs are Clk-domain enables.
module clk_divider_multi
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned DEF_HALF = DEF_HALF_1HZ,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              Sync,
  input  logic              Load,
  input  logic [CH_W-1:0]   LoadCh,
  input  logic [CNT_W-1:0]  LoadVal,
  output logic [NUM_CH-1:0] ClkOut,
  output logic [NUM_CH-1:0] Tick
);

  logic [NUM_CH-1:0] wr;

  // Out-of-range LoadCh matches no index, so such loads fall away here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = Load && (LoadCh == CH_W'(i));

    div_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_div_channel (
      .Clk    (Clk),
      .Rst    (Rst),
      .En     (En),
      .Clr    (Sync),
      .Wr     (wr[i]),
      .WrVal  (LoadVal),
      .ClkOut (ClkOut[i]),
      .Tick   (Tick[i])
    );
  end

endmodule
